// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the sequential divider.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, iteration-counter width function, and
// two's-complement negate / absolute-value helpers. The helpers work on a
// MAX_W-wide container; callers zero-extend into it and size-cast the
// result back, so any operand width up to MAX_W is supported.
package div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ONE_W = MAX_W'(1);

  // The counter must hold values up to a_width.
  function automatic int cnt_w(input int aw);
    return $clog2(aw + 1);
  endfunction

  function automatic logic [MAX_W-1:0] tc_neg(input logic [MAX_W-1:0] x);
    return ~x + ONE_W;
  endfunction

  // is_neg is the operand's sign bit, already gated by tc.
  function automatic logic [MAX_W-1:0] tc_abs(input logic [MAX_W-1:0] x,
                                              input logic is_neg);
    return is_neg ? tc_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   rem_in   partial remainder, always < divisor on entry
//   din      next dividend bit, shifted in as the new LSB
//   divisor  unsigned divisor magnitude
//   rem_out  new partial remainder
//   q_bit    quotient bit produced by this step
module div_seq_step
  import div_seq_pkg::*;
#(
  parameter int b_width = 8
) (
  input  logic [b_width-1:0] rem_in,
  input  logic               din,
  input  logic [b_width-1:0] divisor,
  output logic [b_width-1:0] rem_out,
  output logic               q_bit
);

  logic [b_width:0] trial;
  logic [b_width:0] dvs_x;

  assign trial = {rem_in, din};
  assign dvs_x = {1'b0, divisor};

  // rem_in < divisor, so trial < 2*divisor and the difference fits b_width.
  assign q_bit   = (trial >= dvs_x);
  assign rem_out = q_bit ? b_width'(trial - dvs_x) : trial[b_width-1:0];

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle radix-2 restoring divider, unsigned or two's complement.
// Latency: start at edge E0 -> complete after E0+a_width+1; +1 per hold cycle.
// Backpressure: one op in flight; start while busy ignored (or aborts with DIV_SEQ_ABORT_EN).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   hold          freezes CALC/FIX; no effect in IDLE
//   start, tc     new request and signed-mode select, sampled together with a, b
//   a, b          dividend (a_width), divisor (b_width)
//   complete      result valid, held until the next accepted start
//   divide_by_0   last operation had b == 0
//   quotient      a_width result
//   remainder     b_width result, sign follows the dividend
//
// Build option: define DIV_SEQ_ABORT_EN to let start in CALC/FIX abort and
// restart with the new operands.
module div_seq_unit #(
  parameter int a_width = 8,
  parameter int b_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               start,
  input  logic               tc,
  input  logic [a_width-1:0] a,
  input  logic [b_width-1:0] b,
  output logic               complete,
  output logic               divide_by_0,
  output logic [a_width-1:0] quotient,
  output logic [b_width-1:0] remainder
);

  import div_seq_pkg::*;

  localparam int CW = cnt_w(a_width);
  localparam logic [CW-1:0] LAST = CW'(a_width - 1);
  localparam logic [a_width-1:0] Q_MIN = {1'b1, {(a_width-1){1'b0}}};

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [a_width-1:0] dq;       // dividend bits shifting out, quotient bits shifting in
  logic [b_width-1:0] pr;       // partial remainder
  logic [b_width-1:0] dvs;      // divisor magnitude
  logic [b_width-1:0] a_lo;     // raw dividend low bits, remainder for b == 0
  logic               tc_r;
  logic               neg_q;
  logic               a_neg_r;
  logic               dz;

  logic               a_neg;
  logic               b_neg;
  logic [a_width-1:0] a_abs;
  logic [b_width-1:0] b_abs;
  logic [b_width-1:0] pr_nxt;
  logic               q_bit;
  logic               accept;
  logic [a_width-1:0] q_fix;
  logic [b_width-1:0] r_fix;

  assign a_neg = tc & a[a_width-1];
  assign b_neg = tc & b[b_width-1];
  // Most-negative operands map to 100..0, which reads correctly as unsigned.
  assign a_abs = a_width'(tc_abs(MAX_W'(a), a_neg));
  assign b_abs = b_width'(tc_abs(MAX_W'(b), b_neg));

`ifdef DIV_SEQ_ABORT_EN
  assign accept = start;
`else
  assign accept = start && (state == IDLE);
`endif

  div_seq_step #(
    .b_width (b_width)
  ) u_step (
    .rem_in  (pr),
    .din     (dq[a_width-1]),
    .divisor (dvs),
    .rem_out (pr_nxt),
    .q_bit   (q_bit)
  );

  // Sign correction and divide-by-zero substitution. The most-negative / -1
  // case needs no special handling: the magnitude 100..0 is left unnegated
  // because both signs are negative, which is the required wrap value.
  always_comb begin
    q_fix = dq;
    r_fix = pr;
    if (dz) begin
      r_fix = a_lo;
      if (tc_r) begin
        q_fix = a_neg_r ? Q_MIN : ~Q_MIN;
      end else begin
        q_fix = '1;
      end
    end else begin
      if (neg_q) begin
        q_fix = a_width'(tc_neg(MAX_W'(dq)));
      end
      if (a_neg_r) begin
        r_fix = b_width'(tc_neg(MAX_W'(pr)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      pr          <= '0;
      dvs         <= '0;
      a_lo        <= '0;
      tc_r        <= 1'b0;
      neg_q       <= 1'b0;
      a_neg_r     <= 1'b0;
      dz          <= 1'b0;
      complete    <= 1'b0;
      divide_by_0 <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else if (accept) begin
      // Result registers keep the previous answer until FIX overwrites them.
      state    <= CALC;
      cnt      <= '0;
      dq       <= a_abs;
      pr       <= '0;
      dvs      <= b_abs;
      a_lo     <= a[b_width-1:0];
      tc_r     <= tc;
      neg_q    <= a_neg ^ b_neg;
      a_neg_r  <= a_neg;
      dz       <= (b == '0);
      complete <= 1'b0;
    end else if (!hold) begin
      case (state)
        CALC: begin
          pr  <= pr_nxt;
          dq  <= {dq[a_width-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          divide_by_0 <= dz;
          complete    <= 1'b1;
          cnt         <= '0;
          state       <= IDLE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Testbench for div_seq_unit with a_width = b_width = 8.
// Expected results come from an integer reference model and are queued at
// start; a negedge monitor pops and compares them when complete rises.
module tb_div_seq_unit;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int LAT = AW + 1;

  logic          clk;
  logic          rst;
  logic          hold;
  logic          start;
  logic          tc;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
  logic          complete;
  logic          divide_by_0;
  logic [AW-1:0] quotient;
  logic [BW-1:0] remainder;

  typedef struct {
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    int            done;
  } exp_t;

  exp_t          exp_q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;
  logic          cmp_q = 1'b0;
  logic [AW-1:0] last_q = '0;

  div_seq_unit #(
    .a_width (AW),
    .b_width (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .start       (start),
    .tc          (tc),
    .a           (a),
    .b           (b),
    .complete    (complete),
    .divide_by_0 (divide_by_0),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic [AW-1:0] aa, input logic [BW-1:0] bb,
                                 input logic t, input int done);
    exp_t e;
    int   sa;
    int   sb;
    e.done = done;
    e.dz   = (bb == 0);
    if (bb == 0) begin
      e.r = aa[BW-1:0];
      if (t) e.q = aa[AW-1] ? 8'h80 : 8'h7F;
      else   e.q = 8'hFF;
    end else begin
      sa  = t ? int'($signed(aa)) : int'(aa);
      sb  = t ? int'($signed(bb)) : int'(bb);
      e.q = AW'(sa / sb);
      e.r = BW'(sa % sb);
    end
    return e;
  endfunction

  // Scoreboard monitor: compare on each rising edge of complete.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && complete && !cmp_q) begin
      if (exp_q.size() == 0) begin
        chk("spurious_complete", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("divide_by_0", divide_by_0, e.dz);
        chk("latency_cycle", cyc, e.done);
        last_q = e.q;
      end
    end
    cmp_q = complete;
  end

  // Pulse start for one cycle; returns just after the accepting edge.
  task automatic start_op(input logic [AW-1:0] aa, input logic [BW-1:0] bb,
                          input logic t, input int extra);
    @(posedge clk);
    #1;
    a     = aa;
    b     = bb;
    tc    = t;
    start = 1'b1;
    exp_q.push_back(model(aa, bb, t, cyc + 1 + LAT + extra));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_op(input logic [AW-1:0] aa, input logic [BW-1:0] bb,
                        input logic t, input int hold_n);
    start_op(aa, bb, t, hold_n);
    @(negedge clk);
    chk("busy_complete", complete, 0);
    chk("busy_quotient", quotient, last_q);
    if (hold_n > 0) begin
      repeat (2) @(posedge clk);
      #1 hold = 1'b1;
      repeat (hold_n) @(posedge clk);
      #1 hold = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    rst   = 1'b1;
    hold  = 1'b0;
    start = 1'b0;
    tc    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_complete", complete, 0);
    chk("rst_dz", divide_by_0, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);

    // Directed cases.
    run_op(8'd200, 8'd7, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("hold_complete", complete, 1);
    chk("hold_quotient", quotient, 28);
    run_op(8'hF9, 8'd2, 1'b1, 0);
    run_op(8'd55, 8'd0, 1'b0, 0);
    run_op(8'h80, 8'd0, 1'b1, 0);
    run_op(8'h80, 8'hFF, 1'b1, 3);

    // Reset in the middle of an operation discards it.
    start_op(8'd200, 8'd7, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_complete", complete, 0);
    chk("midrst_dz", divide_by_0, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    last_q = '0;
    run_op(8'd100, 8'd10, 1'b0, 0);

    // Second start while busy.
    start_op(8'd200, 8'd7, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    a     = 8'd9;
    b     = 8'd4;
    tc    = 1'b0;
    start = 1'b1;
`ifdef DIV_SEQ_ABORT_EN
    void'(exp_q.pop_back());
    exp_q.push_back(model(8'd9, 8'd4, 1'b0, cyc + 1 + LAT));
`endif
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Random mix, including zero divisors and hold stalls.
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      ra = AW'($urandom);
      rb = (i % 6 == 5) ? '0 : BW'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    repeat (12) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
